spi_sensor_master: RTL and testbench
====================================

SPI_SENSOR_MASTER -- requirements
Module: spi_sensor_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per spi_sck half-period; legal range 2..255.
REQ-002 Parameter: DATA_BITS, default 16, read-data width per frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request one register-read frame; sampled only in IDLE.
REQ-006 reg_addr  input  7  sensor register address; captured when start is accepted.
REQ-007 spi_miso  input  1  serial data from sensor.
REQ-008 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-009 spi_cs  output  1  chip select, active-low.
REQ-010 spi_mosi  output  1  serial command to sensor.
REQ-011 rd_data  output  DATA_BITS  last completed read word.
REQ-012 data_ready  output  1  one-cycle pulse when rd_data is updated.
REQ-013 busy  output  1  high while a frame or inter-frame gap is in progress.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-015 In IDLE with start=1 at a clk edge, the block SHALL latch cmd = {1'b1, reg_addr}, and on the next cycle drive spi_cs=0, busy=1, spi_mosi=cmd[7], and enter SETUP.
REQ-016 start while not in IDLE SHALL be ignored, with no queuing.
REQ-017 SETUP SHALL last CLK_DIV cycles with spi_sck=0, then enter SHIFT.
REQ-018 SHIFT SHALL toggle spi_sck every CLK_DIV cycles, first toggle 0->1, for exactly 8+DATA_BITS full SCK periods (24 rising edges by default).
REQ-019 spi_mosi SHALL change only on SCK falling edges (after the first bit set in REQ-015): command bits MSB first, then 0 for all data-phase bits.
REQ-020 spi_miso SHALL be sampled at the clk edge that drives spi_sck 0->1.
REQ-021 The first 8 samples SHALL be discarded; the next DATA_BITS samples SHALL be shifted MSB-first into an internal shift register.
REQ-022 After the final SCK falling edge, the block SHALL enter HOLD: spi_sck=0 and spi_cs=0 for CLK_DIV cycles.
REQ-023 On leaving HOLD, in the same cycle the block SHALL drive spi_cs=1, load rd_data from the shift register and pulse data_ready=1 for exactly one cycle, then enter GAP.
REQ-024 GAP SHALL hold spi_cs=1 and busy=1 for CLK_DIV cycles, then enter IDLE with busy=0.
REQ-025 Frame timing: spi_cs low for exactly (2*(8+DATA_BITS)+2)*CLK_DIV cycles (200 at defaults).
REQ-026 Minimum spacing between CS falling edges: that low time plus CLK_DIV+1 cycles.
REQ-027 rd_data SHALL change only in the data_ready cycle and otherwise hold its value.
REQ-028 spi_sck SHALL be 0 whenever spi_cs=1.
REQ-029 start held high continuously SHALL produce back-to-back frames, each separated by GAP; reg_addr is recaptured at each accept.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 With rst=1 at a clk edge, the next cycle SHALL show: state IDLE, spi_cs=1, spi_sck=0, spi_mosi=0, busy=0, data_ready=0, rd_data=0, all counters 0.
REQ-032 rst SHALL take priority over start and over any in-progress frame.
REQ-033 A frame aborted by reset SHALL produce no data_ready pulse and no partial rd_data update.
REQ-034 rst asserted in the same cycle as start SHALL cause that start to be ignored.

Verification
REQ-035 Defaults; reg_addr=0x28, sensor model returns 0xA55A; start pulsed at cycle 0 -> spi_cs low cycles 1..200, MOSI bits 0xA8 then zeros, 24 SCK pulses, rd_data=0xA55A with data_ready=1 at cycle 201 only, busy low from cycle 205.
REQ-036 start pulsed again at cycle 50 during frame -> ignored; exactly one frame, one data_ready.
REQ-037 rst asserted for one cycle after the 10th SCK rising edge -> next cycle spi_cs=1, spi_sck=0, busy=0; no data_ready; rd_data=0.
REQ-038 start held high for 500 cycles, reg_addr=0x0F, model returns 0x1234 then 0xFFFF -> two frames, CS-high gap of 5 cycles (GAP plus IDLE accept), rd_data 0x1234 then 0xFFFF, one pulse each.
REQ-039 CLK_DIV=2, model returns 0x0001 -> SCK period 4 cycles, CS low 100 cycles, rd_data=0x0001 (LSB captured on last rising edge).
REQ-040 Sensor drives MISO=1 during the 8 command bits and 0 during data -> rd_data=0x0000 (command-phase samples discarded).

Source files
------------

// File: rtl/spi_sensor_master.sv
// spi_sensor_master: SPI mode-0 master issuing one register-read frame per start request
module spi_sensor_master #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0]           reg_addr,
  input  logic                 spi_miso,
  output logic                 spi_sck,
  output logic                 spi_cs,
  output logic                 spi_mosi,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 data_ready,
  output logic                 busy
);
  localparam int HALVES = 2 * (8 + DATA_BITS);
  localparam int HW     = $clog2(HALVES);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [HW-1:0]        half_q, half_d;
  logic                 sck_q, sck_d, cs_q, cs_d, busy_q, busy_d, dr_q, dr_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, rd_q, rd_d;
  logic                 tick;
  assign tick       = div_q == 8'(CLK_DIV - 1);
  assign spi_sck    = sck_q;
  assign spi_cs     = cs_q;
  assign spi_mosi   = cmd_q[7];
  assign rd_data    = rd_q;
  assign data_ready = dr_q;
  assign busy       = busy_q;
  // state and registered outputs; reset wins over everything, aborting any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      dr_q    <= 1'b0;
      cmd_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      dr_q    <= dr_d;
      cmd_q   <= cmd_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
    end
  end
  // next state: every phase lasts whole CLK_DIV periods; SCK rises sample MISO, falls advance MOSI
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 8'd1;
    half_d  = half_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    dr_d    = 1'b0;
    cmd_d   = cmd_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cmd_d   = {1'b1, reg_addr};
          sh_d    = '0;
        end
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sck_d   = 1'b1;
        half_d  = '0;
      end
      SHIFT: if (tick) begin
        if (half_q == HW'(HALVES - 1)) state_d = HOLD;
        else begin
          half_d = half_q + 1'b1;
          sck_d  = ~sck_q;
          if (sck_q) cmd_d = {cmd_q[6:0], 1'b0};
          else if (half_q >= HW'(15)) sh_d = {sh_q[DATA_BITS-2:0], spi_miso};
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        cs_d    = 1'b1;
        dr_d    = 1'b1;
        rd_d    = sh_q;
      end
      GAP: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_sensor_master.sv
// tb_spi_sensor_master: directed checks of frame timing, data capture, start filtering and reset abort
module tb_spi_sensor_master;
  logic        clk = 0, rst = 1, start = 0, sel = 0;
  logic [6:0]  reg_addr = 0;
  logic        miso = 0;
  logic        sck1, cs1, mosi1, dr1, busy1, sck2, cs2, mosi2, dr2, busy2;
  logic [15:0] rd1, rd2;
  logic        sck_m, cs_m, mosi_m, dr_m, busy_m;
  logic [15:0] rd_m;
  always #5 clk = ~clk;
  spi_sensor_master dut1 (.clk(clk), .rst(rst), .start(start & ~sel), .reg_addr(reg_addr), .spi_miso(miso),
    .spi_sck(sck1), .spi_cs(cs1), .spi_mosi(mosi1), .rd_data(rd1), .data_ready(dr1), .busy(busy1));
  spi_sensor_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .start(start & sel), .reg_addr(reg_addr), .spi_miso(miso),
    .spi_sck(sck2), .spi_cs(cs2), .spi_mosi(mosi2), .rd_data(rd2), .data_ready(dr2), .busy(busy2));
  assign sck_m  = sel ? sck2 : sck1;
  assign cs_m   = sel ? cs2 : cs1;
  assign mosi_m = sel ? mosi2 : mosi1;
  assign dr_m   = sel ? dr2 : dr1;
  assign busy_m = sel ? busy2 : busy1;
  assign rd_m   = sel ? rd2 : rd1;
  // sensor model: loads {fill, word} on CS fall, shifts out on SCK fall, captures MOSI on SCK rise
  logic [15:0] words [3];
  logic [7:0]  fill = 0;
  int          base = 0, falls_total = 0, mrises = 0;
  logic [23:0] tx = 0, mcap = 0;
  logic        pcs = 1, psck = 0;
  always @(negedge clk) begin
    if (!cs_m && pcs) begin
      tx = {fill, words[(falls_total - base) > 2 ? 2 : (falls_total - base)]};
      falls_total++;
      mcap = 0;
      mrises = 0;
    end else if (!cs_m && !sck_m && psck) tx = {tx[22:0], 1'b0};
    if (sck_m && !psck) begin
      mcap = {mcap[22:0], mosi_m};
      mrises++;
    end
    miso = tx[23];
    pcs = cs_m;
    psck = sck_m;
  end
  int checks = 0, errors = 0;
  int cs_lo_n, cs_first, nf, dr_n, nr, busy_lo, rd_glitch, sck_bad;
  int fall_cyc [4];
  int dr_cyc [4];
  int rise_cyc [2];
  logic [15:0] rd_vals [4];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // watch n cycles starting at cycle 1 (one cycle after the accept edge)
  task automatic mon(input int n, input int pulse, input int hold);
    logic pc, ps;
    logic [15:0] pr;
    cs_lo_n = 0; cs_first = -1; nf = 0; dr_n = 0; nr = 0; busy_lo = -1; rd_glitch = 0; sck_bad = 0;
    pc = 1; ps = 0; pr = rd_m;
    for (int cyc = 1; cyc <= n; cyc++) begin
      start = (cyc == pulse) || (cyc < hold);
      if (!cs_m) begin
        cs_lo_n++;
        if (cs_first < 0) cs_first = cyc;
        if (pc) begin
          if (nf < 4) fall_cyc[nf] = cyc;
          nf++;
        end
      end
      if (dr_m) begin
        if (dr_n < 4) begin
          dr_cyc[dr_n] = cyc;
          rd_vals[dr_n] = rd_m;
        end
        dr_n++;
      end else if (rd_m !== pr) rd_glitch++;
      if (!busy_m && busy_lo < 0) busy_lo = cyc;
      if (cs_m && sck_m) sck_bad++;
      if (sck_m && !ps) begin
        if (nr < 2) rise_cyc[nr] = cyc;
        nr++;
      end
      pc = cs_m; ps = sck_m; pr = rd_m;
      @(posedge clk); #1;
    end
    start = 0;
  endtask
  task automatic run(input int n, input int pulse, input int hold);
    base = falls_total;
    start = 1;
    @(posedge clk); #1;
    mon(n, pulse, hold);
  endtask
  initial begin
    int k;
    words[0] = 0; words[1] = 0; words[2] = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_cs", cs1, 1); chk("rst_sck", sck1, 0); chk("rst_mosi", mosi1, 0);
    chk("rst_busy", busy1, 0); chk("rst_dr", dr1, 0); chk("rst_rd", rd1, 0); chk("rst_cs2", cs2, 1);
    rst = 0;
    // basic frame
    words[0] = 16'hA55A; reg_addr = 7'h28;
    run(230, -1, 0);
    chk("a_cs_first", cs_first, 1); chk("a_cs_low", cs_lo_n, 200); chk("a_dr_n", dr_n, 1);
    chk("a_dr_cyc", dr_cyc[0], 201); chk("a_rd", rd_vals[0], 16'hA55A); chk("a_busy_lo", busy_lo, 205);
    chk("a_mosi", mcap, 24'hA80000); chk("a_rises", mrises, 24); chk("a_sck_cs", sck_bad, 0);
    chk("a_rd_hold", rd_glitch, 0);
    // start during a frame is ignored
    words[0] = 16'h3C96;
    run(260, 50, 0);
    chk("b_frames", nf, 1); chk("b_cs_low", cs_lo_n, 200); chk("b_dr_n", dr_n, 1); chk("b_rd", rd_vals[0], 16'h3C96);
    // reset after 10th SCK rise aborts the frame
    words[0] = 16'hBEEF; base = falls_total;
    start = 1; @(posedge clk); #1; start = 0;
    k = 0;
    for (int i = 0; i < 200 && k < 10; i++) begin
      @(posedge clk); #1;
      if (sck1 && !psck) k++;
    end
    chk("c_rise10", k, 10);
    rst = 1; @(posedge clk); #1; rst = 0;
    chk("c_cs", cs1, 1); chk("c_sck", sck1, 0); chk("c_busy", busy1, 0); chk("c_rd", rd1, 0); chk("c_mosi", mosi1, 0);
    mon(30, -1, 0);
    chk("c_no_dr", dr_n, 0); chk("c_no_frame", nf, 0);
    // start coinciding with reset is dropped
    rst = 1; start = 1; @(posedge clk); #1; rst = 0; start = 0;
    chk("d_cs", cs1, 1); chk("d_busy", busy1, 0);
    mon(20, -1, 0);
    chk("d_no_frame", nf, 0);
    // start held high: back-to-back frames
    words[0] = 16'h1234; words[1] = 16'hFFFF; words[2] = 16'hFFFF; reg_addr = 7'h0F;
    run(500, -1, 500);
    chk("e_dr_n", dr_n, 2); chk("e_rd0", rd_vals[0], 16'h1234); chk("e_rd1", rd_vals[1], 16'hFFFF);
    chk("e_dr1_cyc", dr_cyc[1], 406); chk("e_gap", fall_cyc[1] - dr_cyc[0], 5); chk("e_rd_hold", rd_glitch, 0);
    for (int i = 0; i < 400 && busy1; i++) begin @(posedge clk); #1; end
    chk("e_drain", busy1, 0); chk("e_mosi3", mcap, 24'h8F0000);
    // fast divider
    sel = 1; words[0] = 16'h0001;
    run(120, -1, 0);
    chk("f_cs_low", cs_lo_n, 100); chk("f_dr_cyc", dr_cyc[0], 101); chk("f_rd", rd_vals[0], 16'h0001);
    chk("f_period", rise_cyc[1] - rise_cyc[0], 4); chk("f_rises", nr, 24); chk("f_busy_lo", busy_lo, 103);
    // command-phase MISO samples are discarded
    sel = 0; fill = 8'hFF; words[0] = 16'h0000;
    run(230, -1, 0);
    chk("g_dr_n", dr_n, 1); chk("g_rd", rd_vals[0], 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
